// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler: FSM encoding, display limits
// and the round-robin pick helper.
package disp_pkg;

  localparam int DATA_W     = 16;
  localparam int BCD_DIGITS = 4;
  localparam logic [DATA_W-1:0] MAX_DISPLAY = 16'd9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } disp_state_e;

  // Returns {found, index}. Scanning from farthest to nearest lets the requester
  // just after 'last' overwrite all others, so it wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock, DATA_W steps.
// done and bcd are combinational during the final step so the caller can commit on that edge.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  logic [DATA_W-1:0]       bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [3:0]              cnt_q, cnt_d;
  logic                    active_q, active_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      bin_d    = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bin_d = {bin_q[DATA_W-2:0], 1'b0};
      bcd_d = {adj[4*BCD_DIGITS-2:0], bin_q[DATA_W-1]};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) active_d = 1'b0;
    end
  end

  assign done = active_q && (cnt_q == 4'd15) && !start;
  assign bcd  = {adj[4*BCD_DIGITS-2:0], bin_q[DATA_W-1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin display owner: arbitrates requesters, converts the winner's clamped value
// to BCD over 16 cycles, then holds it on display for HOLD_CYCLES before re-arbitrating.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000000,
  parameter int NUM_REQ     = 4
) (
  input  logic                      clock_100Mhz,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] src_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         disp_data_o,
  output logic [DATA_W-1:0]         bcd_o,
  output logic                      overflow_o,
  output logic                      busy_o,
  output logic [1:0]                state_o
);

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  disp_state_e         state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
  logic [1:0]          last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   val_q, val_d, disp_q, disp_d, bcd_q, bcd_d;
  logic                ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;

  logic [2:0]          pick;
  logic [1:0]          win;
  logic [DATA_W-1:0]   win_data, win_clamped, conv_bcd;
  logic                conv_start, conv_done;

  assign pick        = rr_pick(req_i, last_q);
  assign win         = pick[1:0];
  assign win_data    = src_data_i[{win, 4'b0000} +: DATA_W];
  assign win_clamped = (win_data > MAX_DISPLAY) ? MAX_DISPLAY : win_data;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    last_d     = last_q;
    hold_d     = hold_q;
    val_d      = val_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick[2]) begin
          state_d    = ST_CONV;
          conv_start = 1'b1;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_HOLD;
          disp_d  = val_q;
          bcd_d   = conv_bcd;
          ovf_d   = ovf_pend_q;
          ack_d   = grant_q;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          if (pick[2]) begin
            state_d    = ST_CONV;
            conv_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Winner is captured here; later src_data_i changes do not reach the display.
    if (conv_start) begin
      grant_d    = NUM_REQ'(1) << win;
      last_d     = win;
      val_d      = win_clamped;
      ovf_pend_d = (win_data > MAX_DISPLAY);
      hold_d     = '0;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk_i (clock_100Mhz),
    .rst_i (reset),
    .start (conv_start),
    .bin   (win_clamped),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      last_q     <= 2'd3;
      hold_q     <= '0;
      val_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      val_q      <= val_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign disp_data_o = disp_q;
  assign bcd_o       = bcd_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a commit scoreboard and HOLD_CYCLES=4.
module tb_display_scheduler;
  import disp_pkg::*;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req;
  logic [63:0] src;
  logic [3:0]  grant_o, ack_o;
  logic [15:0] disp_data_o, bcd_o;
  logic        overflow_o, busy_o;
  logic [1:0]  state_o;

  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  display_scheduler #(.HOLD_CYCLES(HOLD), .NUM_REQ(4)) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .req_i        (req),
    .src_data_i   (src),
    .grant_o      (grant_o),
    .ack_o        (ack_o),
    .disp_data_o  (disp_data_o),
    .bcd_o        (bcd_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Expected commit record: {grant, display value, bcd, overflow}
  function automatic logic [36:0] make_exp(input logic [3:0] g, input int v);
    int c;
    logic [15:0] b;
    c = (v > 9999) ? 9999 : v;
    b = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    return {g, 16'(c), b, (v > 9999)};
  endfunction

  task automatic wait_commit(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack_o != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_commit(input string tag);
    logic [36:0] e;
    check({tag, "_sb_has_entry"}, 64'(exp_q.size() != 0), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'd0;
    check({tag, "_grant"}, 64'(grant_o), 64'(e[36:33]));
    check({tag, "_ack"}, 64'(ack_o), 64'(e[36:33]));
    check({tag, "_disp"}, 64'(disp_data_o), 64'(e[32:17]));
    check({tag, "_bcd"}, 64'(bcd_o), 64'(e[16:1]));
    check({tag, "_ovf"}, 64'(overflow_o), 64'(e[0]));
  endtask

  // One isolated request from IDLE through commit and back to IDLE.
  task automatic run_single(input string tag, input logic [3:0] r, input logic [3:0] g,
                            input int slot, input int v);
    int tn;
    logic ok;
    @(negedge clk);
    req = r;
    src[slot*16 +: 16] = 16'(v);
    exp_q.push_back(make_exp(g, v));
    @(negedge clk);
    tn = cyc;
    check({tag, "_grant_after_edge"}, 64'(grant_o), 64'(g));
    check({tag, "_busy_conv"}, 64'(busy_o), 64'd1);
    req = 4'b0000;
    wait_commit(40, ok);
    check({tag, "_commit_seen"}, 64'(ok), 64'd1);
    check({tag, "_latency"}, 64'(cyc - tn), 64'd16);
    check({tag, "_busy_commit"}, 64'(busy_o), 64'd1);
    check_commit(tag);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 64'(ack_o), 64'd0);
    wait_idle(20, ok);
    check({tag, "_idle_reached"}, 64'(ok), 64'd1);
    check({tag, "_disp_held_idle"}, 64'(disp_data_o), 64'(make_exp(g, v) >> 17 & 37'hFFFF));
  endtask

  initial begin
    logic ok;
    int tprev, tc, acks;
    int rv[4];
    req = 4'b0000;
    src = '0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_disp", 64'(disp_data_o), 64'd0);
    check("rst_bcd", 64'(bcd_o), 64'd0);
    check("rst_state", 64'(state_o), 64'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic commit, then clamp/overflow sequence on requester 1
    run_single("basic1234", 4'b0001, 4'b0001, 0, 1234);
    run_single("ovf12345", 4'b0010, 4'b0010, 1, 12345);
    run_single("max9999", 4'b0010, 4'b0010, 1, 9999);
    run_single("zero", 4'b0010, 4'b0010, 1, 0);

    // Fresh reset, then all four requesting continuously
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rv[k] = int'($urandom_range(0, 20000));
      src[k*16 +: 16] = 16'(rv[k]);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(make_exp(4'(1 << (k % 4)), rv[k % 4]));
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_commit(60, ok);
      check("rr_commit_seen", 64'(ok), 64'd1);
      if (k > 0) check("rr_spacing", 64'(cyc - tprev), 64'd20);
      tprev = cyc;
      check_commit("rr");
      if (k == 4) req = 4'b0000;
    end
    wait_idle(20, ok);
    check("rr_idle_reached", 64'(ok), 64'd1);

    // Request raised during HOLD waits for hold expiry; value latched at grant
    @(negedge clk);
    req = 4'b0100;
    rv[0] = int'($urandom_range(0, 9999));
    src[47:32] = 16'(rv[0]);
    exp_q.push_back(make_exp(4'b0100, rv[0]));
    @(negedge clk);
    check("hold_first_grant", 64'(grant_o), 64'b0100);
    req = 4'b0000;
    wait_commit(40, ok);
    check("hold_first_commit_seen", 64'(ok), 64'd1);
    tc = cyc;
    check_commit("hold_first");
    req = 4'b0001;
    rv[1] = int'($urandom_range(10, 9999));
    src[15:0] = 16'(rv[1]);
    exp_q.push_back(make_exp(4'b0001, rv[1]));
    @(negedge clk);
    @(negedge clk);
    check("hold_grant_kept", 64'(grant_o), 64'b0100);
    check("hold_state", 64'(state_o), 64'(ST_HOLD));
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant_o == 4'b0001) begin
        ok = 1'b1;
        break;
      end
    end
    check("hold_regrant_seen", 64'(ok), 64'd1);
    check("hold_regrant_time", 64'(cyc - tc), 64'(HOLD));
    req = 4'b0000;
    repeat (7) @(negedge clk);
    src[15:0] = 16'(rv[1] - 7);
    wait_commit(40, ok);
    check("hold_second_commit_seen", 64'(ok), 64'd1);
    check("hold_commit_spacing", 64'(cyc - tc), 64'd20);
    check_commit("hold_second");
    wait_idle(20, ok);
    check("hold_idle_reached", 64'(ok), 64'd1);

    // Reset in the middle of a conversion discards it
    @(negedge clk);
    req = 4'b0010;
    src[31:16] = 16'd4321;
    @(negedge clk);
    check("abort_grant", 64'(grant_o), 64'b0010);
    req = 4'b0000;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_rst_grant", 64'(grant_o), 64'd0);
    check("abort_rst_ack", 64'(ack_o), 64'd0);
    check("abort_rst_busy", 64'(busy_o), 64'd0);
    check("abort_rst_ovf", 64'(overflow_o), 64'd0);
    check("abort_rst_disp", 64'(disp_data_o), 64'd0);
    check("abort_rst_bcd", 64'(bcd_o), 64'd0);
    check("abort_rst_state", 64'(state_o), 64'(ST_IDLE));
    acks = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (ack_o != 4'b0000) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    run_single("post_reset", 4'b0110, 4'b0010, 1, 777);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 100000000, the number of clock cycles a committed value stays on display before the next arbitration (1 s at 100 MHz); minimum legal value is 1.
REQ-002 Parameter NUM_REQ, fixed at 4, the number of requesters.
REQ-003 clock_100Mhz  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  4  per-requester display request; level-sensitive.
REQ-006 src_data_i  input  64  packed 16-bit binary values; requester k occupies bits [16k+15:16k].
REQ-007 grant_o  output  4  one-hot index of the requester owning the display; all zero when none has been granted.
REQ-008 ack_o  output  4  one-cycle pulse to the granted requester when its value is committed.
REQ-009 disp_data_o  output  16  committed binary value, clamped to 9999.
REQ-010 bcd_o  output  16  committed value as four BCD digits, thousands digit in [15:12].
REQ-011 overflow_o  output  1  high while the committed value was clamped.
REQ-012 busy_o  output  1  high in CONV and HOLD.

Function
REQ-013 The FSM SHALL have three states: IDLE, CONV and HOLD.
- IDLE -> CONV: any req_i bit is high at a rising edge.
- CONV -> HOLD: after exactly 16 CONV cycles.
- HOLD -> CONV: HOLD_CYCLES complete and a request is pending.
- HOLD -> IDLE: HOLD_CYCLES complete and no request is pending.
REQ-014 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping 3->0; after reset the last-granted index is 3, so requester 0 has first priority.
REQ-015 On the edge entering CONV, the block SHALL:
- register grant_o;
- latch the winner's 16-bit value, ignoring later src_data_i changes;
- load the clamped value, min(value, 9999), into the converter;
- register overflow-pending if value > 9999.
REQ-016 CONV SHALL perform one shift-and-add-3 (double-dabble) step per cycle, 16 steps in total.
REQ-017 On the 16th CONV edge, bcd_o, disp_data_o and overflow_o SHALL update together, and ack_o[granted] SHALL pulse for exactly one cycle.
- Latency: request sampled at edge N produces committed outputs at edge N+16.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles, counted from the commit edge.
- req_i changes during CONV or HOLD SHALL NOT abort or extend the hold.
REQ-019 Between commits, and in IDLE, bcd_o, disp_data_o, overflow_o and grant_o SHALL hold their last committed values.
REQ-020 A requester that drops req_i before its grant SHALL simply not be selected; no ack is issued to it.
- Simultaneous requests SHALL be resolved by REQ-014 only.
REQ-021 The hold counter SHALL be wide enough for HOLD_CYCLES without wrap-around, and SHALL reset to zero on every CONV entry.

Reset
REQ-022 While reset is high, the block SHALL hold these values immediately, independent of the clock:
- state IDLE;
- grant_o = 0, ack_o = 0, busy_o = 0, overflow_o = 0;
- disp_data_o = 0, bcd_o = 16'h0000;
- last-granted index = 3.
REQ-023 Reset asserted during CONV or HOLD SHALL discard the conversion in flight, with no ack.
REQ-024 After reset is released, the first request SHALL be handled as a fresh IDLE arbitration.

Structure
REQ-025 A shared package/header disp_pkg SHALL hold:
- the state encoding;
- MAX_DISPLAY = 9999;
- BCD_DIGITS = 4;
- DATA_W = 16.
REQ-026 The iterative converter SHALL be a sub-module named bin2bcd_seq with ports:
- start (input), bin (16, input);
- done (1-cycle pulse, output), bcd (16, output).
REQ-027 bcd_o SHALL be consumed by the existing four-digit seven-segment driver through its 16-bit data input, replacing per-digit division.

Verification
REQ-028 Reset; req_i=0001, src_data[15:0]=1234 -> grant_o=0001 after edge N; at edge N+16 bcd_o=16'h1234, ack_o=0001 for one cycle, busy_o=1.
REQ-029 req_i=0010, value 12345 -> disp_data_o=9999, bcd_o=16'h9999, overflow_o=1; a following value 9999 -> overflow_o=0; value 0 -> bcd_o=16'h0000.
REQ-030 HOLD_CYCLES=4, req_i=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001; commits spaced exactly 20 cycles apart.
REQ-031 req_i=0100 committed, then req_i=0001 raised during HOLD with src_data changed mid-CONV -> requester 0 granted only after the hold expires; the displayed value is the one latched at grant.
REQ-032 Reset pulsed at CONV cycle 8 -> all outputs at reset values asynchronously, no ack_o pulse; the next request is granted from requester 0 priority.
